compare_seq_ctrl: RTL and testbench

Sequencing controller that compares two WIDTH-bit unsigned operands with one shared 4-bit magnitude comparator, examining one nibble per cycle from MSB to LSB and stopping at the first unequal nibble. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It lets wide compares in the branch/ALU path reuse a single compare_4bit slice instead of a full-width comparator.

---
 rtl/compare_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_compare_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/compare_seq_ctrl.sv
// rtl/compare_seq_ctrl.sv - nibble-serial wide magnitude compare sequencer (optional macro COMPARE_SIGNED_EN)

module compare_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);

    // Single-slice unsigned magnitude comparison
    always_comb begin
        eq = (a == b);
        gt = (a > b);
        lt = (a < b);
    end

endmodule

module compare_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic             equal_o,
    output logic             alarger_o,
    output logic             blarger_o,
    output logic             busy_o
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   a_cmp;
    logic [WIDTH-1:0]   b_cmp;
    logic [IDX_W-1:0]   idx_q;
    logic               eq_q;
    logic               agt_q;
    logic               blt_q;
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic               nib_eq;
    logic               nib_gt;
    logic               nib_lt;

`ifdef COMPARE_SIGNED_EN
    // Flipping the sign bit maps two's complement ordering onto unsigned ordering
    assign a_cmp = {~a_q[WIDTH-1], a_q[WIDTH-2:0]};
    assign b_cmp = {~b_q[WIDTH-1], b_q[WIDTH-2:0]};
`else
    assign a_cmp = a_q;
    assign b_cmp = b_q;
`endif

    // Route the nibble selected by idx to the shared comparator slice
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_cmp[4*i +: 4];
                b_nib = b_cmp[4*i +: 4];
            end
        end
    end

    compare_4bit u_cmp (
        .a  (a_nib),
        .b  (b_nib),
        .eq (nib_eq),
        .gt (nib_gt),
        .lt (nib_lt)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; stray encodings recover to IDLE
    always_comb begin
        state_d        = state_q;
        start_ready_o  = 1'b0;
        result_valid_o = 1'b0;
        busy_o         = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready_o = 1'b1;
                if (start_valid_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (!nib_eq || (idx_q == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_o         = 1'b1;
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, nibble walk and result flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= '0;
            eq_q  <= 1'b0;
            agt_q <= 1'b0;
            blt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid_i) begin
                        a_q   <= a_i;
                        b_q   <= b_i;
                        idx_q <= IDX_W'(NIBBLES - 1);
                        eq_q  <= 1'b0;
                        agt_q <= 1'b0;
                        blt_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (!nib_eq) begin
                        eq_q  <= 1'b0;
                        agt_q <= nib_gt;
                        blt_q <= nib_lt;
                    end else if (idx_q == '0) begin
                        eq_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign equal_o   = eq_q;
    assign alarger_o = agt_q;
    assign blarger_o = blt_q;

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// tb/tb_compare_seq_ctrl.sv - directed vector bench for compare_seq_ctrl

module tb_compare_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        result_valid;
    logic        result_ready = 1'b1;
    logic        equal;
    logic        alarger;
    logic        blarger;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        eq;
        logic        agt;
        logic        blt;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    compare_seq_ctrl #(.WIDTH(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_valid_i  (start_valid),
        .start_ready_o  (start_ready),
        .a_i            (a),
        .b_i            (b),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready),
        .equal_o        (equal),
        .alarger_o      (alarger),
        .blarger_o      (blarger),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called just after a negedge with the DUT in IDLE; returns at the negedge where valid is first seen
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
        check("start_ready_before_accept", {31'b0, start_ready}, 32'd1);
        start_valid = 1'b1;
        a = av;
        b = bv;
        tick();
        start_valid = 1'b0;
        a = 32'hAAAA_AAAA;
        b = 32'h5555_5555;
        lat = 1;
        while (!result_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{32'hF000_0000, 32'h0FFF_FFFF, 1'b0, 1'b1, 1'b0, 2};
`ifdef COMPARE_SIGNED_EN
        vecs[0] = '{32'hF000_0000, 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b1, 2};
`endif
        vecs[1] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 9};
        vecs[2] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 9};
        vecs[3] = '{32'h1234_5678, 32'h1234_5778, 1'b0, 1'b0, 1'b1, 7};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 9};
        vecs[5] = '{32'h7FFF_FFFF, 32'h7FFE_FFFF, 1'b0, 1'b1, 1'b0, 5};
        vecs[6] = '{32'h0A00_0000, 32'h0900_0000, 1'b0, 1'b1, 1'b0, 3};
        vecs[7] = '{32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 8};

        // Reset state
        #2;
        check("rst_start_ready", {31'b0, start_ready}, 32'd1);
        check("rst_valid", {31'b0, result_valid}, 32'd0);
        check("rst_flags", {29'b0, equal, alarger, blarger}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Table-driven compares with the consumer always ready
        result_ready = 1'b1;
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_equal", i), {31'b0, equal}, {31'b0, vecs[i].eq});
            check($sformatf("v%0d_alarger", i), {31'b0, alarger}, {31'b0, vecs[i].agt});
            check($sformatf("v%0d_blarger", i), {31'b0, blarger}, {31'b0, vecs[i].blt});
            tick();
            check($sformatf("v%0d_valid_one_cycle", i), {31'b0, result_valid}, 32'd0);
            check($sformatf("v%0d_back_idle", i), {31'b0, start_ready}, 32'd1);
        end

        // Reset in the middle of RUN discards the operation
        start_valid = 1'b1;
        a = 32'h1234_5678;
        b = 32'h1234_5679;
        tick();
        start_valid = 1'b0;
        tick();
        check("midrun_busy_before_reset", {31'b0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_start_ready", {31'b0, start_ready}, 32'd1);
        check("midrun_rst_valid", {31'b0, result_valid}, 32'd0);
        check("midrun_rst_flags", {29'b0, equal, alarger, blarger}, 32'd0);
        check("midrun_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (result_valid) seen++;
        end
        check("midrun_no_result", seen, 0);

        // Backpressure holds the result and ignores new starts
        result_ready = 1'b0;
        run_op(32'h0000_0008, 32'h0000_0007, lat);
        check("bp_latency", lat, 9);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid_%0d", i), {31'b0, result_valid}, 32'd1);
            check($sformatf("bp_flags_%0d", i), {29'b0, equal, alarger, blarger}, 32'b010);
            check($sformatf("bp_start_ready_%0d", i), {31'b0, start_ready}, 32'd0);
            if (i == 1) begin
                start_valid = 1'b1;
                a = 32'h0000_0001;
                b = 32'h0000_0002;
            end
            if (i == 2) start_valid = 1'b0;
            tick();
        end
        result_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'b0, result_valid}, 32'd0);
        check("bp_release_idle", {31'b0, start_ready}, 32'd1);
        check("bp_flags_held", {29'b0, equal, alarger, blarger}, 32'b010);
        tick();
        check("bp_pulse_not_queued", {31'b0, busy}, 32'd0);

        // Back-to-back with start_valid held high
        result_ready = 1'b1;
        start_valid = 1'b1;
        a = 32'h2000_0000;
        b = 32'h1000_0000;
        tick();
        a = 32'h0000_0001;
        b = 32'h0000_0002;
        tick();
        check("b2b_first_valid", {31'b0, result_valid}, 32'd1);
        check("b2b_first_flags", {29'b0, equal, alarger, blarger}, 32'b010);
        tick();
        check("b2b_idle_after_handshake", {31'b0, start_ready}, 32'd1);
        check("b2b_idle_valid_low", {31'b0, result_valid}, 32'd0);
        tick();
        start_valid = 1'b0;
        check("b2b_second_accepted", {31'b0, busy}, 32'd1);
        check("b2b_flags_cleared", {29'b0, equal, alarger, blarger}, 32'd0);
        lat = 1;
        while (!result_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b_second_latency", lat, 9);
        check("b2b_second_flags", {29'b0, equal, alarger, blarger}, 32'b001);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
